// File: rtl/tpu_pkg.sv
// Shared definitions for the tile scheduler: FSM state encoding and default tile edge.
package tpu_pkg;

    localparam int unsigned TILE_DEFAULT = 4;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitStart,
        StWaitDone,
        StAdvance,
        StFinish
    } sched_state_e;

    // States that contribute to the job cycle counter.
    function automatic logic counts_cycles(sched_state_e s);
        return (s == StIssue) || (s == StWaitStart) || (s == StWaitDone) || (s == StAdvance);
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Registered per-tile index generator: computes buffer indexes for tile (m, n) one cycle
// after load, holding them until the next load.
module tile_addr_gen #(
    parameter int unsigned TILE  = 4,
    parameter int unsigned IDX_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [7:0]       m,
    input  logic [7:0]       n,
    input  logic [7:0]       n_tiles,
    input  logic [IDX_W-1:0] k,
    input  logic [IDX_W-1:0] a_base,
    input  logic [IDX_W-1:0] b_base,
    input  logic [IDX_W-1:0] c_base,
    output logic [IDX_W-1:0] a_index,
    output logic [IDX_W-1:0] b_index,
    output logic [IDX_W-1:0] c_index,
    output logic [IDX_W-1:0] k_out
);

    localparam logic [IDX_W-1:0] TileW = IDX_W'(TILE);

    logic [IDX_W-1:0] m_w;
    logic [IDX_W-1:0] n_w;
    logic [IDX_W-1:0] nt_w;
    logic [IDX_W-1:0] a_index_q;
    logic [IDX_W-1:0] b_index_q;
    logic [IDX_W-1:0] c_index_q;
    logic [IDX_W-1:0] k_q;

    assign m_w  = IDX_W'(m);
    assign n_w  = IDX_W'(n);
    assign nt_w = IDX_W'(n_tiles);

    // All arithmetic is IDX_W wide so results wrap modulo 2^IDX_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_index_q <= '0;
            b_index_q <= '0;
            c_index_q <= '0;
            k_q       <= '0;
        end else if (load) begin
            a_index_q <= a_base + m_w * k;
            b_index_q <= b_base + n_w * k;
            c_index_q <= c_base + (m_w * nt_w + n_w) * TileW;
            k_q       <= k;
        end
    end

    assign a_index = a_index_q;
    assign b_index = b_index_q;
    assign c_index = c_index_q;
    assign k_out   = k_q;

endmodule

// File: rtl/tile_scheduler.sv
// Walks an M x N grid of output tiles, issuing one systolic-array run per tile and
// reporting completion, abort status, tile count and job cycle count.
module tile_scheduler
    import tpu_pkg::*;
#(
    parameter int unsigned TILE  = TILE_DEFAULT,
    parameter int unsigned IDX_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [7:0]       job_m_tiles,
    input  logic [7:0]       job_n_tiles,
    input  logic [IDX_W-1:0] job_k,
    input  logic [IDX_W-1:0] a_base,
    input  logic [IDX_W-1:0] b_base,
    input  logic [IDX_W-1:0] c_base,
    input  logic             abort,
    output logic             sa_enable,
    input  logic             sa_busy,
    output logic [IDX_W-1:0] sa_k,
    output logic [IDX_W-1:0] sa_a_index,
    output logic [IDX_W-1:0] sa_b_index,
    output logic [IDX_W-1:0] sa_c_index,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [15:0]      tiles_done,
    output logic [31:0]      cycle_count
);

    sched_state_e     state_q, state_d;
    logic [7:0]       m_tiles_q, n_tiles_q;
    logic [7:0]       m_q, n_q, m_nxt, n_nxt;
    logic [IDX_W-1:0] k_q, a_base_q, b_base_q, c_base_q;
    logic             zero_job_q;
    logic             abort_q;
    logic             aborted_q;
    logic [15:0]      tiles_done_q;
    logic [31:0]      cycle_count_q;

    logic             accept;
    logic             abort_seen;
    logic             last_tile;

    logic             gen_load;
    logic [7:0]       gen_m, gen_n, gen_n_tiles;
    logic [IDX_W-1:0] gen_k, gen_a, gen_b, gen_c;

    always_comb begin
        abort_seen = abort_q | abort;
        last_tile  = (m_q == m_tiles_q - 8'd1) && (n_q == n_tiles_q - 8'd1);
        if (n_q == n_tiles_q - 8'd1) begin
            n_nxt = '0;
            m_nxt = m_q + 8'd1;
        end else begin
            n_nxt = n_q + 8'd1;
            m_nxt = m_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        job_ready   = 1'b0;
        sa_enable   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        accept      = 1'b0;
        gen_load    = 1'b0;
        gen_m       = m_nxt;
        gen_n       = n_nxt;
        gen_n_tiles = n_tiles_q;
        gen_k       = k_q;
        gen_a       = a_base_q;
        gen_b       = b_base_q;
        gen_c       = c_base_q;
        case (state_q)
            StIdle: begin
                busy      = 1'b0;
                job_ready = 1'b1;
                if (job_valid) begin
                    accept      = 1'b1;
                    state_d     = StIssue;
                    // Indexes for tile (0,0) come straight from the job inputs.
                    gen_load    = 1'b1;
                    gen_m       = '0;
                    gen_n       = '0;
                    gen_n_tiles = job_n_tiles;
                    gen_k       = job_k;
                    gen_a       = a_base;
                    gen_b       = b_base;
                    gen_c       = c_base;
                end
            end
            StIssue: begin
                if (zero_job_q) begin
                    state_d = StFinish;
                end else begin
                    sa_enable = 1'b1;
                    state_d   = StWaitStart;
                end
            end
            StWaitStart: if (sa_busy) state_d = StWaitDone;
            StWaitDone:  if (!sa_busy) state_d = StAdvance;
            StAdvance: begin
                if (last_tile || abort_seen) begin
                    state_d = StFinish;
                end else begin
                    state_d  = StIssue;
                    gen_load = 1'b1;
                end
            end
            StFinish: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            m_tiles_q     <= '0;
            n_tiles_q     <= '0;
            m_q           <= '0;
            n_q           <= '0;
            k_q           <= '0;
            a_base_q      <= '0;
            b_base_q      <= '0;
            c_base_q      <= '0;
            zero_job_q    <= 1'b0;
            abort_q       <= 1'b0;
            aborted_q     <= 1'b0;
            tiles_done_q  <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != StIdle) abort_q <= abort_q | abort;
            if (accept) begin
                m_tiles_q     <= job_m_tiles;
                n_tiles_q     <= job_n_tiles;
                k_q           <= job_k;
                a_base_q      <= a_base;
                b_base_q      <= b_base;
                c_base_q      <= c_base;
                zero_job_q    <= (job_m_tiles == 8'd0) || (job_n_tiles == 8'd0) || (job_k == '0);
                m_q           <= '0;
                n_q           <= '0;
                abort_q       <= 1'b0;
                aborted_q     <= 1'b0;
                tiles_done_q  <= '0;
                cycle_count_q <= '0;
            end
            if (state_q == StAdvance) begin
                tiles_done_q <= tiles_done_q + 16'd1;
                m_q          <= m_nxt;
                n_q          <= n_nxt;
            end
            if (counts_cycles(state_q) && (cycle_count_q != '1)) begin
                cycle_count_q <= cycle_count_q + 32'd1;
            end
            // Decided on entry so aborted is valid in the same cycle as done.
            if ((state_d == StFinish) && (state_q != StFinish)) aborted_q <= abort_seen;
        end
    end

    tile_addr_gen #(
        .TILE  (TILE),
        .IDX_W (IDX_W)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (gen_load),
        .m       (gen_m),
        .n       (gen_n),
        .n_tiles (gen_n_tiles),
        .k       (gen_k),
        .a_base  (gen_a),
        .b_base  (gen_b),
        .c_base  (gen_c),
        .a_index (sa_a_index),
        .b_index (sa_b_index),
        .c_index (sa_c_index),
        .k_out   (sa_k)
    );

    assign aborted     = aborted_q;
    assign tiles_done  = tiles_done_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: a job-level model predicts the tile sequence,
// indexes, counts and status; directed jobs pin the model with literal expectations.
module tb_tile_scheduler;

    localparam int TILE = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] k;
    } tile_t;

    logic        clk, reset;
    logic        job_valid, job_ready, abort, sa_enable, sa_busy;
    logic [7:0]  job_m_tiles, job_n_tiles;
    logic [15:0] job_k, a_base, b_base, c_base;
    logic [15:0] sa_k, sa_a_index, sa_b_index, sa_c_index;
    logic        busy, done, aborted;
    logic [15:0] tiles_done;
    logic [31:0] cycle_count;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    // Model state, written only by the compare process.
    bit    in_job, abort_seen, legal;
    int    job_cycles, issued, total, stop_at, last_cycles, last_tiles;
    int    accept_cyc, first_en_cyc, done_cyc, done_cnt;
    int    done_tiles, done_aborted, done_cycles;
    tile_t exp_q[$];
    tile_t en_log[$];
    tile_t cur, act, t;

    // Array model knobs.
    int arr_lat = 3;
    int arr_delay = 1;
    int arr_cnt, arr_pend;

    tile_scheduler #(
        .TILE  (4),
        .IDX_W (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_m_tiles (job_m_tiles),
        .job_n_tiles (job_n_tiles),
        .job_k       (job_k),
        .a_base      (a_base),
        .b_base      (b_base),
        .c_base      (c_base),
        .abort       (abort),
        .sa_enable   (sa_enable),
        .sa_busy     (sa_busy),
        .sa_k        (sa_k),
        .sa_a_index  (sa_a_index),
        .sa_b_index  (sa_b_index),
        .sa_c_index  (sa_c_index),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .tiles_done  (tiles_done),
        .cycle_count (cycle_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Array model: busy rises arr_delay cycles after an enable and stays high arr_lat cycles.
    initial begin
        sa_busy = 0;
        arr_cnt = 0;
        arr_pend = 0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                arr_cnt = 0;
                arr_pend = 0;
            end else begin
                if (arr_cnt > 0) arr_cnt--;
                if (arr_pend > 0) begin
                    arr_pend--;
                    if (arr_pend == 0) arr_cnt = arr_lat;
                end
                if (sa_enable) arr_pend = arr_delay;
            end
            sa_busy = (arr_cnt > 0);
        end
    end

    // Compare process: job-level model checked every cycle on the falling edge.
    initial begin
        in_job = 0;
        last_cycles = 0;
        last_tiles = 0;
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_job = 0;
                abort_seen = 0;
                exp_q.delete();
                last_cycles = 0;
                last_tiles = 0;
            end else begin
                check("busy", busy, in_job);
                check("job_ready", job_ready, !in_job);
                if (in_job) begin
                    check("cycle_count", cycle_count, job_cycles);
                end else begin
                    check("idle cycle_count hold", cycle_count, last_cycles);
                    check("idle tiles_done hold", tiles_done, last_tiles);
                end
                if (sa_enable) begin
                    legal = in_job && (exp_q.size() > 0) && !(abort_seen && issued >= stop_at);
                    check("sa_enable legal", legal, 1);
                    if (legal) begin
                        cur = exp_q.pop_front();
                        check("sa_a_index", sa_a_index, cur.a);
                        check("sa_b_index", sa_b_index, cur.b);
                        check("sa_c_index", sa_c_index, cur.c);
                        check("sa_k", sa_k, cur.k);
                        act = '{a: sa_a_index, b: sa_b_index, c: sa_c_index, k: sa_k};
                        en_log.push_back(act);
                        if (issued == 0) first_en_cyc = cyc;
                        issued++;
                    end
                end
                if (in_job && sa_busy && issued > 0) begin
                    check("stable a", sa_a_index, cur.a);
                    check("stable b", sa_b_index, cur.b);
                    check("stable c", sa_c_index, cur.c);
                    check("stable k", sa_k, cur.k);
                end
                if (done) begin
                    check("done inside job", in_job, 1);
                    check("tiles_done at done", tiles_done, issued);
                    check("tiles issued", issued, abort_seen ? stop_at : total);
                    check("aborted at done", aborted, abort_seen);
                    in_job = 0;
                    last_cycles = job_cycles;
                    last_tiles = issued;
                    done_cyc = cyc;
                    done_cnt++;
                    done_tiles = tiles_done;
                    done_aborted = aborted;
                    done_cycles = cycle_count;
                end else if (in_job) begin
                    job_cycles++;
                end
                if (in_job && abort && !abort_seen) begin
                    abort_seen = 1;
                    stop_at = issued;
                end
                if (!in_job && !done && job_valid) begin
                    exp_q.delete();
                    en_log.delete();
                    total = 0;
                    if (job_k != 0) begin
                        for (int mi = 0; mi < int'(job_m_tiles); mi++) begin
                            for (int ni = 0; ni < int'(job_n_tiles); ni++) begin
                                t.a = 16'(int'(a_base) + mi * int'(job_k));
                                t.b = 16'(int'(b_base) + ni * int'(job_k));
                                t.c = 16'(int'(c_base) + (mi * int'(job_n_tiles) + ni) * TILE);
                                t.k = job_k;
                                exp_q.push_back(t);
                                total++;
                            end
                        end
                    end
                    in_job = 1;
                    job_cycles = 0;
                    issued = 0;
                    abort_seen = 0;
                    accept_cyc = cyc;
                end
            end
        end
    end

    task automatic drive_job(input logic [7:0] m, input logic [7:0] n, input logic [15:0] k,
                             input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        job_m_tiles = m;
        job_n_tiles = n;
        job_k = k;
        a_base = a;
        b_base = b;
        c_base = c;
        job_valid = 1;
    endtask

    task automatic start_job(input logic [7:0] m, input logic [7:0] n, input logic [15:0] k,
                             input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        bit got = 0;
        @(posedge clk);
        #1;
        drive_job(m, n, k, a, b, c);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (job_ready) begin
                got = 1;
                break;
            end
        end
        check("job accepted", got, 1);
        @(posedge clk);
        #1;
        job_valid = 0;
    endtask

    task automatic wait_done(input int budget);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        check("done within budget", got, 1);
        @(posedge clk);
        #3;
    endtask

    task automatic check_reset_vals();
        check("rst sa_enable", sa_enable, 0);
        check("rst done", done, 0);
        check("rst aborted", aborted, 0);
        check("rst busy", busy, 0);
        check("rst tiles_done", tiles_done, 0);
        check("rst cycle_count", cycle_count, 0);
        check("rst sa_a_index", sa_a_index, 0);
        check("rst sa_b_index", sa_b_index, 0);
        check("rst sa_c_index", sa_c_index, 0);
        check("rst sa_k", sa_k, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_a[6];
        logic [15:0] exp_b[6];
        logic [15:0] exp_c[6];
        int dc;
        exp_a = '{16'd0, 16'd0, 16'd0, 16'd16, 16'd16, 16'd16};
        exp_b = '{16'd0, 16'd16, 16'd32, 16'd0, 16'd16, 16'd32};
        exp_c = '{16'd0, 16'd4, 16'd8, 16'd12, 16'd16, 16'd20};

        reset = 1;
        abort = 0;
        job_valid = 0;
        job_m_tiles = 0;
        job_n_tiles = 0;
        job_k = 0;
        a_base = 0;
        b_base = 0;
        c_base = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 0;

        // Single tile, long array run.
        arr_lat = 10;
        start_job(8'd1, 8'd1, 16'd8, 16'h0000, 16'h0100, 16'h0200);
        wait_done(100);
        check("1x1 enables", en_log.size(), 1);
        if (en_log.size() == 1) begin
            check("1x1 a", en_log[0].a, 16'h0000);
            check("1x1 b", en_log[0].b, 16'h0100);
            check("1x1 c", en_log[0].c, 16'h0200);
            check("1x1 k", en_log[0].k, 16'd8);
        end
        check("1x1 tiles_done", done_tiles, 1);
        check("1x1 first enable latency", first_en_cyc - accept_cyc, 1);
        check("1x1 done latency", done_cyc - accept_cyc, 14);
        check("1x1 cycle_count", done_cycles, 13);

        // 2x3 grid.
        arr_lat = 3;
        start_job(8'd2, 8'd3, 16'd16, 16'h0000, 16'h0000, 16'h0000);
        wait_done(200);
        check("2x3 enables", en_log.size(), 6);
        if (en_log.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("2x3 a[%0d]", i), en_log[i].a, exp_a[i]);
                check($sformatf("2x3 b[%0d]", i), en_log[i].b, exp_b[i]);
                check($sformatf("2x3 c[%0d]", i), en_log[i].c, exp_c[i]);
            end
        end
        check("2x3 tiles_done", done_tiles, 6);

        // Empty job.
        start_job(8'd0, 8'd4, 16'd8, 16'h0000, 16'h0000, 16'h0000);
        wait_done(20);
        check("empty enables", en_log.size(), 0);
        check("empty done latency", done_cyc - accept_cyc, 2);
        check("empty tiles_done", done_tiles, 0);
        check("empty cycle_count", done_cycles, 1);

        // Abort during tile 0 run.
        arr_lat = 6;
        start_job(8'd2, 8'd2, 16'd4, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sa_busy) break;
        end
        @(posedge clk);
        #1;
        abort = 1;
        @(posedge clk);
        #1;
        abort = 0;
        wait_done(100);
        check("abort tiles_done", done_tiles, 1);
        check("abort aborted", done_aborted, 1);
        check("abort enables", en_log.size(), 1);

        // Delayed array start; job_valid during a running job must be ignored.
        arr_lat = 4;
        arr_delay = 3;
        start_job(8'd1, 8'd2, 16'd8, 16'h0010, 16'h0020, 16'h0030);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sa_busy) break;
        end
        @(posedge clk);
        #1;
        drive_job(8'd7, 8'd7, 16'd99, 16'h1111, 16'h2222, 16'h3333);
        repeat (3) @(posedge clk);
        #1;
        job_valid = 0;
        wait_done(100);
        check("ignore enables", en_log.size(), 2);
        if (en_log.size() == 2) check("ignore b[1]", en_log[1].b, 16'h0028);
        check("ignore tiles_done", done_tiles, 2);
        arr_delay = 1;

        // Index wrap on second row.
        arr_lat = 3;
        start_job(8'd2, 8'd1, 16'd32, 16'hFFF0, 16'h0000, 16'h0000);
        wait_done(100);
        check("wrap enables", en_log.size(), 2);
        if (en_log.size() == 2) begin
            check("wrap a[0]", en_log[0].a, 16'hFFF0);
            check("wrap a[1]", en_log[1].a, 16'h0010);
        end

        // Reset during tile 1 run, then a fresh job.
        arr_lat = 6;
        start_job(8'd2, 8'd2, 16'd4, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #3;
            if (en_log.size() >= 2 && sa_busy) break;
        end
        @(posedge clk);
        #1;
        reset = 1;
        dc = done_cnt;
        @(posedge clk);
        #1;
        check_reset_vals();
        @(posedge clk);
        #1;
        reset = 0;
        drive_job(8'd1, 8'd1, 16'd2, 16'h0040, 16'h0050, 16'h0060);
        @(negedge clk);
        check("ready after reset", job_ready, 1);
        @(posedge clk);
        #1;
        job_valid = 0;
        wait_done(100);
        check("no done from abandoned job", done_cnt, dc + 1);
        check("post-reset tiles_done", done_tiles, 1);
        check("post-reset aborted", done_aborted, 0);
        if (en_log.size() == 1) check("post-reset c", en_log[0].c, 16'h0060);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tile_scheduler.md
TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 SHALL have parameter TILE, default 4, systolic array edge (rows/cols per tile).
REQ-002 SHALL have parameter IDX_W, default 16, buffer index width.
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port job_valid / job_ready  in / out  1 / 1  job handshake; accepted when both high on a clk edge.
REQ-006 SHALL have port job_m_tiles, job_n_tiles  in  8 each  output tile rows / tile cols.
REQ-007 SHALL have port job_k  in  IDX_W  reduction depth.
REQ-008 SHALL have port a_base, b_base, c_base  in  IDX_W each  buffer base indexes.
REQ-009 SHALL have port abort  in  1  stop after the in-flight tile.
REQ-010 SHALL have port sa_enable  out  1  one-cycle start pulse to the systolic array.
REQ-011 SHALL have port sa_busy  in  1  array busy flag.
REQ-012 SHALL have port sa_k, sa_a_index, sa_b_index, sa_c_index  out  IDX_W each  per-tile K and base indexes, stable while the tile runs.
REQ-013 SHALL have port busy  out  1  job in progress.
REQ-014 SHALL have port done  out  1  one-cycle pulse at job end.
REQ-015 SHALL have port aborted  out  1  high with done when ended by abort.
REQ-016 SHALL have port tiles_done  out  16  tiles completed in current/last job.
REQ-017 SHALL have port cycle_count  out  32  cycles from accept to done.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT_START, WAIT_DONE, ADVANCE, FINISH.
REQ-019 SHALL assert job_ready only in IDLE; on accept, latch all job inputs, clear tiles_done/cycle_count/aborted, m=n=0, go to ISSUE.
REQ-020 SHALL go directly to FINISH (no sa_enable) when job_m_tiles, job_n_tiles or job_k is 0.
REQ-021 ISSUE SHALL drive sa_enable high for exactly one cycle (first ISSUE cycle = cycle after accept), then go to WAIT_START.
REQ-022 Indexes SHALL be sa_a_index = a_base + m*K, sa_b_index = b_base + n*K, sa_c_index = c_base + (m*N + n)*TILE, sa_k = K, all truncated modulo 2^IDX_W.
REQ-023 WAIT_START SHALL wait for sa_busy=1, then go to WAIT_DONE; WAIT_DONE SHALL wait for sa_busy=0, then go to ADVANCE.
REQ-024 ADVANCE SHALL increment tiles_done, step n (inner), wrapping to 0 with m+1; go to FINISH after last tile (m=M-1, n=N-1) or if abort was seen, else ISSUE.
REQ-025 abort SHALL be sticky-latched in any non-IDLE state; never interrupts WAIT_START/WAIT_DONE; ignored in IDLE.
REQ-026 FINISH SHALL pulse done for one cycle, set aborted if abort latched, return to IDLE.
REQ-027 busy SHALL be high in every state except IDLE.
REQ-028 cycle_count SHALL increment each cycle in non-IDLE states except FINISH, saturating at 2^32-1; hold in IDLE.
REQ-029 job_valid while busy SHALL be ignored (not latched).

Reset
REQ-030 On reset: state IDLE, sa_enable=0, done=0, aborted=0, busy=0, tiles_done=0, cycle_count=0, index/K outputs 0, abort latch cleared.
REQ-031 Reset mid-job SHALL abandon the job with no done pulse; job_ready=1 the cycle after reset deasserts.

Structure
REQ-032 State encoding and TILE default SHALL live in shared package tpu_pkg.
REQ-033 Index multiply-add SHALL be a sub-module tile_addr_gen (registered, 1-cycle latency, computed during ADVANCE/accept so ISSUE sees valid indexes).

Verification
REQ-034 M=1,N=1,K=8, bases 0/0x100/0x200; array model busy 10 cycles -> one sa_enable, indexes 0/0x100/0x200, done, tiles_done=1.
REQ-035 M=2,N=3,K=16, bases 0 -> 6 enables, c indexes 0,4,8,12,16,20, a indexes 0,0,0,16,16,16, b indexes 0,16,32,0,16,32.
REQ-036 M=0,N=4,K=8 -> no sa_enable, done two cycles after accept, tiles_done=0.
REQ-037 M=2,N=2, abort pulsed during tile 0 WAIT_DONE -> tile 0 completes, done with aborted=1, tiles_done=1.
REQ-038 Reset asserted in WAIT_DONE of tile 1 -> all outputs at reset values, no done; new job accepted next cycle runs normally.
REQ-039 a_base=0xFFF0, K=32, M=2 -> second-row sa_a_index=0x0010 (wrap).
